// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and the pointer-width helper
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: single write port, asynchronous read port storage with no reset
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with registered or first-word-fall-through read
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int FWFT = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             put,
  input  logic             get,
  output logic [WIDTH-1:0] data_out,
  output logic [AW:0]      fillcount,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_N = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_N = (AW+1)'(AE_LEVEL);
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [WIDTH-1:0] rdata, dout_q;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == FULL_N;
  assign almost_full = count >= AF_N;
  assign almost_empty = count <= AE_N;
  assign fillcount = count;
  assign wr = put & ~full & ~clear;
  assign rd = get & ~empty & ~clear;
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(wr),
    .waddr(wp),
    .wdata(data_in),
    .raddr(rp),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= rd ? rp + AW'(1) : rp;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      overflow <= overflow | (put & full);
      underflow <= underflow | (get & empty);
    end
  // In fall-through mode dout_q remembers the last shown word so an empty FIFO keeps displaying it
  always_ff @(posedge clk or posedge reset)
    if (reset) dout_q <= '0;
    else dout_q <= (FWFT != 0) ? data_out : (rd ? rdata : dout_q);
  assign data_out = (FWFT != 0 && !empty) ? rdata : dout_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table, directed and random checks of both read modes against a queue model
module tb_sync_fifo_param;
  localparam int W = 8;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset, clear, put, get;
  logic [W-1:0] data_in, dout0, dout1;
  logic [3:0] cnt0, cnt1;
  logic e0, f0, ae0, af0, ov0, un0;
  logic e1, f1, ae1, af1, ov1, un1;
  always #5 clk = ~clk;
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .put(put), .get(get),
    .data_out(dout0), .fillcount(cnt0), .empty(e0), .full(f0), .almost_empty(ae0),
    .almost_full(af0), .overflow(ov0), .underflow(un0)
  );
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .data_in(data_in), .put(put), .get(get),
    .data_out(dout1), .fillcount(cnt1), .empty(e1), .full(f1), .almost_empty(ae1),
    .almost_full(af1), .overflow(ov1), .underflow(un1)
  );
  typedef struct {
    bit put;
    bit get;
    logic [7:0] din;
    int cnt;
    logic [7:0] dout;
    bit full;
    bit empty;
  } vec_t;
  vec_t tbl[16];
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit m_ov, m_un;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_model();
    int n;
    n = q.size();
    chk("fillcount", 32'(cnt0), n);
    chk("fillcount_fwft", 32'(cnt1), n);
    chk("empty", 32'(e0), 32'(n == 0));
    chk("full", 32'(f0), 32'(n == D));
    chk("almost_empty", 32'(ae0), 32'(n <= 2));
    chk("almost_full", 32'(af0), 32'(n >= 6));
    chk("empty_fwft", 32'(e1), 32'(n == 0));
    chk("overflow", 32'(ov0), 32'(m_ov));
    chk("underflow", 32'(un0), 32'(m_un));
    chk("data_out", 32'(dout0), 32'(m_dout));
    if (n != 0) chk("data_out_fwft", 32'(dout1), 32'(q[0]));
  endtask
  task automatic step(input bit p, input bit g, input bit c, input logic [7:0] d);
    bit was_full, was_empty;
    put = p;
    get = g;
    clear = c;
    data_in = d;
    was_full = q.size() == D;
    was_empty = q.size() == 0;
    if (c) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (p && was_full) m_ov = 1'b1;
      if (g && was_empty) m_un = 1'b1;
      if (g && !was_empty) m_dout = q.pop_front();
      if (p && !was_full) q.push_back(d);
    end
    @(posedge clk);
    #1;
    put = 1'b0;
    get = 1'b0;
    clear = 1'b0;
    check_model();
  endtask
  initial begin
    reset = 1'b1;
    clear = 1'b0;
    put = 1'b0;
    get = 1'b0;
    data_in = '0;
    m_dout = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_model();
    chk("reset_dout", 32'(dout0), 0);
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 8'(i + 1), i + 1, 8'h00, i == 7, 1'b0};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b0, 1'b1, 8'h00, 7 - i, 8'(i + 1), 1'b0, i == 7};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].put, tbl[i].get, 1'b0, tbl[i].din);
      chk("tbl_cnt", 32'(cnt0), tbl[i].cnt);
      chk("tbl_dout", 32'(dout0), 32'(tbl[i].dout));
      chk("tbl_full", 32'(f0), 32'(tbl[i].full));
      chk("tbl_empty", 32'(e0), 32'(tbl[i].empty));
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(16 + i));
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    chk("ovf_cnt", 32'(cnt0), 8);
    chk("ovf_set", 32'(ov0), 1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_sticky", 32'(ov0), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("ovf_no_aa", 32'(dout0), 32'(16 + i));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_cnt", 32'(cnt0), 0);
    chk("clr_ovf", 32'(ov0), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf_set", 32'(un0), 1);
    chk("unf_dout", 32'(dout0), 32'h17);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b1, 1'b0, 8'h99);
    chk("fpg_cnt", 32'(cnt0), 7);
    chk("fpg_dout", 32'(dout0), 32'h30);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    repeat (20) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      chk("hold4_cnt", 32'(cnt0), 4);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h5C);
    chk("fwft_dout", 32'(dout1), 32'h5C);
    chk("fwft_nonempty", 32'(e1), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fwft_empty", 32'(e1), 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt0), 0);
    chk("arst_empty", 32'(e0), 1);
    chk("arst_dout", 32'(dout0), 0);
    chk("arst_dout_fwft", 32'(dout1), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_dout = '0;
    m_ov = 1'b0;
    m_un = 1'b0;
    check_model();
    repeat (400)
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3, 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, 8: data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, 8: number of entries, SHALL be a power of two >= 2.
REQ-003 Parameter FWFT, 0: read mode, 0 = registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, DEPTH-2: almost_full threshold, SHALL be in 1..DEPTH.
REQ-005 Parameter AE_LEVEL, 2: almost_empty threshold, SHALL be in 0..DEPTH-1.
REQ-006 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port clear, input, 1: synchronous flush.
REQ-009 Port data_in, input, WIDTH: write data.
REQ-010 Port put, input, 1: write request.
REQ-011 Port get, input, 1: read request.
REQ-012 Port data_out, output, WIDTH: read data.
REQ-013 Port fillcount, output, AW+1 (AW = log2 DEPTH): current number of stored words.
REQ-014 Ports empty, full, almost_empty, almost_full, output, 1 each: status flags.
REQ-015 Ports overflow, underflow, output, 1 each: sticky error flags.

Function
REQ-016 A write SHALL be accepted iff put=1 and full=0; an accepted write SHALL store data_in at wp and advance wp modulo DEPTH.
REQ-017 A read SHALL be accepted iff get=1 and empty=0; an accepted read SHALL advance rp modulo DEPTH.
REQ-018 fillcount SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous accepted write and read.
REQ-019 When full, put with get SHALL accept the read only; when empty, put with get SHALL accept the write only.
REQ-020 Flags SHALL be decoded from the registered fillcount only: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-021 Flags SHALL have no combinational path from put or get.
REQ-022 With FWFT=0, data_out SHALL load mem[rp] on the clock edge of an accepted read (1-cycle latency) and SHALL otherwise hold its value.
REQ-023 With FWFT=1, data_out SHALL present mem[rp] whenever empty=0, the first word SHALL be visible the cycle after the write into an empty FIFO, and get SHALL pop the displayed word.
REQ-024 overflow SHALL set on the cycle after put=1 with full=1; underflow SHALL set on the cycle after get=1 with empty=1.
REQ-025 overflow and underflow SHALL remain set until reset or clear.
REQ-026 clear SHALL zero wp, rp, fillcount, overflow and underflow, SHALL override put and get in the same cycle, and SHALL not alter memory contents or data_out.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated word.

Reset
REQ-028 reset SHALL asynchronously zero wp, rp, fillcount, data_out, overflow and underflow, giving empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 reset asserted mid-operation SHALL discard all stored words.

Structure
REQ-031 Package fifo_pkg SHALL hold the clog2 helper function and the default WIDTH/DEPTH constants.
REQ-032 Storage SHALL be a sub-module fifo_ram (1 write port, 1 asynchronous read port, no reset) instantiated once.
REQ-033 Pointer, count and flag logic SHALL reside in sync_fifo_param.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 Write 0x01..0x08 then read 8 times (FWFT=0) -> data_out 0x01..0x08, each one cycle after its get; full=1 after the 8th write; empty=1 after the 8th read.
REQ-035 Fill to 8, then put=1 with data_in=0xAA for 1 cycle -> fillcount stays 8, overflow=1 and sticky, 0xAA never read; pulse clear -> fillcount=0, overflow=0.
REQ-036 When empty, get=1 -> underflow=1 and data_out unchanged; when full, put=1 with get=1 -> fillcount 7 and read data correct.
REQ-037 Hold count at 4, then put=1 and get=1 for 20 cycles -> fillcount stays 4, pointers wrap repeatedly, and the output stream equals the input stream in order.
REQ-038 FWFT=1: single write of 0x5C into empty FIFO -> data_out=0x5C and empty=0 the next cycle with no get; get -> empty=1.
REQ-039 Write 5 words, assert reset mid-cycle -> empty=1, fillcount=0 and data_out=0 immediately, before the next clock edge.
